// File: rtl/read_fifo_pixel_unpack.sv
// read_fifo_pixel_unpack: unpacks show-ahead FIFO words into a pixel stream
// aligned (one cycle late) with the incoming vs/hs/de timing. Partial words
// are flushed at every frame start; missing data is replaced by a fixed
// colour so a late burst never shifts the image.
//
// Handshake: fifo_data is valid whenever fifo_vld=1; a word transfers on a
// rising rd_clk edge where fifo_vld & fifo_rd_en. fifo_rd_en never depends on
// fifo_vld, so there is no combinational loop through the FIFO.
module read_fifo_pixel_unpack #(
  parameter int                   PIX_WIDTH     = 16,
  parameter int                   WORD_WIDTH    = 32,
  parameter logic [PIX_WIDTH-1:0] UNDERFLOW_PIX = 16'hF800
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic [WORD_WIDTH-1:0] fifo_data,
  input  logic                  fifo_vld,
  output logic                  fifo_rd_en,
  input  logic                  vs_in,
  input  logic                  hs_in,
  input  logic                  de_in,
  output logic                  vs_out,
  output logic                  hs_out,
  output logic                  de_out,
  output logic [PIX_WIDTH-1:0]  pix_data,
  output logic                  underflow,
  output logic                  misalign,
  output logic [15:0]           underflow_cnt,
  output logic                  state_dbg_o
);

  // WORD_WIDTH must be RATIO*PIX_WIDTH with RATIO in {1,2,4,8}.
  localparam int RATIO  = WORD_WIDTH / PIX_WIDTH;
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(RATIO - 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic                    vs_d_q;
  logic [WORD_WIDTH-1:0]   word_q, word_d;
  logic                    word_vld_q, word_vld_d;
  logic [LANE_W-1:0]       lane_q, lane_d;
  logic                    vs_out_q, hs_out_q, de_out_q;
  logic [PIX_WIDTH-1:0]    pix_q, pix_d;
  logic                    underflow_q, underflow_d;
  logic                    misalign_q, misalign_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [PIX_WIDTH-1:0]    lane_pix;

  logic active, vs_rise, consume, emit, last, load;

  assign active  = (state_q == ACTIVE);
  assign vs_rise = vs_in & ~vs_d_q;
  assign consume = active & de_in & ~vs_rise;
  assign emit    = consume & word_vld_q;
  assign last    = emit & (lane_q == LANE_LAST);
  // Pop when the holding register is empty or is being drained this cycle.
  assign fifo_rd_en = active & ~vs_rise & (~word_vld_q | last);
  assign load       = fifo_vld & fifo_rd_en;

  assign vs_out        = vs_out_q;
  assign hs_out        = hs_out_q;
  assign de_out        = de_out_q;
  assign pix_data      = pix_q;
  assign underflow     = underflow_q;
  assign misalign      = misalign_q;
  assign underflow_cnt = cnt_q;
  assign state_dbg_o   = active;

  // Select the current lane of the held word (lane 0 = least significant).
  always_comb begin
    lane_pix = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (lane_q == LANE_W'(i)) lane_pix = word_q[i*PIX_WIDTH +: PIX_WIDTH];
    end
  end

  // Next-state: mode, holding register, lane counter and output pixel.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    word_vld_d  = word_vld_q;
    lane_d      = lane_q;
    pix_d       = '0;
    underflow_d = 1'b0;
    misalign_d  = 1'b0;
    cnt_d       = cnt_q;

    if (vs_rise) state_d = ACTIVE;

    if (emit) lane_d = (RATIO == 1) ? '0 : lane_q + LANE_W'(1);
    if (last) word_vld_d = 1'b0;
    if (load) begin
      word_d     = fifo_data;
      word_vld_d = 1'b1;
      lane_d     = '0;
    end

    // Frame start drops any partially used word.
    if (vs_rise) begin
      word_vld_d = 1'b0;
      lane_d     = '0;
      misalign_d = active & word_vld_q & (lane_q != '0);
    end

    // Active pixel: real data if held, otherwise the fill colour.
    if ((active | vs_rise) & de_in) begin
      if (emit) begin
        pix_d = lane_pix;
      end else begin
        pix_d       = UNDERFLOW_PIX;
        underflow_d = 1'b1;
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end
    end
  end

  // State and output registers; everything clears asynchronously.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q     <= IDLE;
      vs_d_q      <= 1'b0;
      word_q      <= '0;
      word_vld_q  <= 1'b0;
      lane_q      <= '0;
      vs_out_q    <= 1'b0;
      hs_out_q    <= 1'b0;
      de_out_q    <= 1'b0;
      pix_q       <= '0;
      underflow_q <= 1'b0;
      misalign_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      vs_d_q      <= vs_in;
      word_q      <= word_d;
      word_vld_q  <= word_vld_d;
      lane_q      <= lane_d;
      vs_out_q    <= vs_in;
      hs_out_q    <= hs_in;
      de_out_q    <= de_in;
      pix_q       <= pix_d;
      underflow_q <= underflow_d;
      misalign_q  <= misalign_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
